bram_port_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 21 ++
 rtl/rr_lock_arbiter.sv | 78 +++++++
 rtl/bram_port_arbiter.sv | 108 ++++++++++
 tb/tb_bram_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Wide enough for the largest supported requester count (8).
    localparam int PIPE_ID_W = 3;

    // Requester-id width for a given requester count.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic                 valid;
        logic [PIPE_ID_W-1:0] id;
    } rd_entry_t;

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with burst locking. Owns the rotation pointer,
// the lock flag and the consecutive locked-beat counter.
module rr_lock_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 16,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_lock,
    input  logic               issue,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [ID_W-1:0]  last_grant;
    logic             lock_active;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_hold;
    logic [CNT_W-1:0] cnt_next;
    logic [ID_W:0]    idx;
    logic             found;

    // Locked owner wins outright while it stays valid; otherwise scan from last_grant+1.
    always_comb begin
        lock_hold = lock_active & req_valid[last_grant];
        grant     = '0;
        winner    = '0;
        found     = 1'b0;
        idx       = '0;
        if (lock_hold) begin
            grant[last_grant] = 1'b1;
            winner            = last_grant;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = {1'b0, last_grant} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_REQ)) begin
                    idx = idx - (ID_W+1)'(NUM_REQ);
                end
                if (!found && req_valid[idx[ID_W-1:0]]) begin
                    found                 = 1'b1;
                    winner                = idx[ID_W-1:0];
                    grant[idx[ID_W-1:0]]  = 1'b1;
                end
            end
        end
    end

    // A fresh lock starts counting at 1; a continuing one adds to the run.
    assign cnt_next = (lock_hold ? lock_cnt : '0) + CNT_W'(1);

    // Pointer and lock bookkeeping; the lock drops once the run hits MAX_LOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= ID_W'(NUM_REQ - 1);
            lock_active <= 1'b0;
            lock_cnt    <= '0;
        end else if (issue) begin
            last_grant <= winner;
            if (req_lock[winner] && (cnt_next < CNT_W'(MAX_LOCK))) begin
                lock_active <= 1'b1;
                lock_cnt    <= cnt_next;
            end else begin
                lock_active <= 1'b0;
                lock_cnt    <= '0;
            end
        end else if (lock_active && !req_valid[last_grant]) begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters: arbitration, request
// mux onto the port, and read-response routing through the BRAM latency.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0] req_wmask,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic [ADDR_W-1:0]                bram_addr,
    output logic [DATA_W-1:0]                bram_wdata,
    output logic [DATA_W/8-1:0]              bram_wmask,
    output logic                             bram_wen,
    input  logic [DATA_W-1:0]                bram_rdata,
    output logic                             busy
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam int LAT  = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                          (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               issue;
    logic               rd_issue;
    rd_entry_t          pipe [LAT];

    rr_lock_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .issue     (issue),
        .grant     (grant),
        .winner    (winner)
    );

    // No grants while reset is held, even if requesters are already valid.
    assign req_ready = rst ? '0 : grant;
    assign issue     = |(req_valid & req_ready);
    assign rd_issue  = issue & ~req_we[winner];

    // Drive the port from the winner; park it at zero when idle.
    always_comb begin
        bram_addr  = '0;
        bram_wdata = '0;
        bram_wmask = '0;
        bram_wen   = 1'b0;
        if (issue) begin
            bram_addr  = req_addr[winner];
            bram_wdata = req_wdata[winner];
            bram_wmask = req_wmask[winner];
            bram_wen   = req_we[winner];
        end
    end

    // Tag each read with its requester and age it alongside the BRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= rd_issue;
            pipe[0].id    <= PIPE_ID_W'(winner);
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Route returning data to the tagged requester; data bus is zero otherwise.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = pipe[LAT-1].valid && (pipe[LAT-1].id == PIPE_ID_W'(i));
        end
        if (pipe[LAT-1].valid) begin
            rsp_rdata = bram_rdata;
        end
    end

    // Busy while any read is still travelling through the return pipeline.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | pipe[i].valid;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: reference arbitration/memory model feeds a
// response scoreboard; directed phases cover ordering, lock and latency.
module tb_bram_port_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int RD_LAT   = 3;
    localparam int MAX_LOCK = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [3:0][31:0]        req_addr;
    logic [3:0][63:0]        req_wdata;
    logic [3:0][7:0]         req_wmask;
    logic [63:0]             rsp_rdata, bram_wdata, bram_rdata;
    logic [31:0]             bram_addr;
    logic [7:0]              bram_wmask;
    logic                    bram_wen, busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        int          id;
        logic [63:0] data;
    } exp_t;
    exp_t sb [$];

    int  m_last;
    bit  m_locked;
    int  m_run;

    logic [63:0]  ref_mem  [128];
    logic [63:0]  bram_mem [128];
    logic [127:0] bw_valid = '0;
    logic [63:0]  rd_pipe  [RD_LAT];

    bram_port_arbiter #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
        .RD_LAT (RD_LAT), .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_lock (req_lock), .req_addr (req_addr), .req_wdata (req_wdata),
        .req_wmask (req_wmask), .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
        .bram_addr (bram_addr), .bram_wdata (bram_wdata), .bram_wmask (bram_wmask),
        .bram_wen (bram_wen), .bram_rdata (bram_rdata), .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(input int i);
        logic [15:0] k;
        k = 16'(i);
        return {16'hA5A5, k, 16'h5A5A, ~k};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [6:0] midx(input logic [31:0] a);
        return a[9:3];
    endfunction

    function automatic logic [63:0] bram_read(input logic [6:0] i);
        return bw_valid[i] ? bram_mem[i] : init_val(int'(i));
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // BRAM model: write commits at the edge, read data emerges RD_LAT cycles later.
    always @(posedge clk) begin
        if (bram_wen) begin
            bram_mem[midx(bram_addr)] <= merge(bram_read(midx(bram_addr)), bram_wdata, bram_wmask);
            bw_valid[midx(bram_addr)] <= 1'b1;
        end
        rd_pipe[0] <= bram_read(midx(bram_addr));
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
        req_addr[i] = a; req_wdata[i] = d; req_wmask[i] = m;
    endtask

    task automatic clr_all();
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = NUM_REQ - 1;
        m_locked = 1'b0;
        m_run = 0;
    endtask

    // Reference: predict the winner, check the port, feed the scoreboard.
    initial begin
        int   w;
        logic [3:0] eg;
        exp_t e;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            w  = -1;
            eg = '0;
            if (!rst) begin
                if (m_locked && req_valid[m_last]) w = m_last;
                else w = rr_pick(req_valid, m_last);
                if (w >= 0) eg[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(eg));
            if (w >= 0) begin
                chk("bram_addr", 64'(bram_addr), 64'(req_addr[w]));
                chk("bram_wen", 64'(bram_wen), 64'(req_we[w]));
                chk("bram_wmask", 64'(bram_wmask), 64'(req_wmask[w]));
                chk("bram_wdata", bram_wdata, req_wdata[w]);
                if (req_we[w]) begin
                    ref_mem[midx(req_addr[w])] = merge(ref_mem[midx(req_addr[w])], req_wdata[w], req_wmask[w]);
                end else begin
                    e.due = cyc + RD_LAT; e.id = w; e.data = ref_mem[midx(req_addr[w])];
                    sb.push_back(e);
                end
                if (req_lock[w]) begin
                    m_run = (m_locked && w == m_last) ? m_run + 1 : 1;
                    m_locked = (m_run < MAX_LOCK);
                    if (!m_locked) m_run = 0;
                end else begin
                    m_locked = 1'b0;
                    m_run = 0;
                end
                m_last = w;
            end else begin
                chk("idle_bram_addr", 64'(bram_addr), 64'd0);
                chk("idle_bram_wen", 64'(bram_wen), 64'd0);
                chk("idle_bram_wmask", 64'(bram_wmask), 64'd0);
                if (m_locked && !req_valid[m_last]) begin
                    m_locked = 1'b0;
                    m_run = 0;
                end
            end
        end
    end

    // Monitor: pop on every response, check timing, routing, data and busy.
    initial begin
        logic eb;
        exp_t e;
        forever begin
            @(negedge clk);
            eb = 1'b0;
            foreach (sb[i]) if (sb[i].due <= cyc + RD_LAT - 1) eb = 1'b1;
            chk("busy", 64'(busy), 64'(eb));
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.id);
                    chk("rsp_rdata", rsp_rdata, e.data);
                end
            end else begin
                chk("idle_rsp_rdata", rsp_rdata, 64'd0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("missing_rsp_valid", 64'd0, 64'd1 << e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] iv, exp_data;
        int          tr [$];
        int          c0, c3, guard;
        logic        busy_tr [6];
        logic [3:0]  rsp_tr  [6];

        // Reset with requests already pending: nothing may be granted.
        clr_all();
        req_valid = '1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_bram_wen", 64'(bram_wen), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        next_cycle();
        clr_all();
        rst = 1'b0;

        // Idle stretch.
        repeat (10) next_cycle();

        // All four read continuously: strict 0,1,2,3 rotation.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'(i * 8), 64'd0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rr_order", 64'(req_ready), 64'd1 << (k % 4));
            next_cycle();
        end
        clr_all();
        repeat (RD_LAT + 2) next_cycle();

        // Partial write then immediate read-back of the same word.
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h40, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        next_cycle();
        clr_all();
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h40, 64'd0, 8'd0);
        next_cycle();
        clr_all();
        repeat (RD_LAT - 1) @(posedge clk);
        @(negedge clk);
        iv = init_val(8);
        exp_data = {iv[63:32], 32'hCAFEF00D};
        chk("wr_rd_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("wr_rd_rsp_rdata", rsp_rdata, exp_data);
        next_cycle();
        repeat (3) next_cycle();

        // Two reads in flight, then reset: they must vanish.
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h08, 64'd0, 8'd0);
        next_cycle();
        clr_all();
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h18, 64'd0, 8'd0);
        next_cycle();
        clr_all();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            next_cycle();
        end

        // Locked burst of 20 from requester 0 against requester 3.
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h100, 64'd0, 8'd0);
        set_req(3, 1'b1, 1'b0, 1'b0, 32'h180, 64'd0, 8'd0);
        c0 = 0; c3 = 0; guard = 0;
        while ((c0 < 20 || c3 < 1) && guard < 100) begin
            @(negedge clk);
            if (req_ready[0]) begin c0++; tr.push_back(0); end
            else if (req_ready[3]) begin c3++; tr.push_back(3); end
            next_cycle();
            req_valid[0] = (c0 < 20);
            req_valid[3] = (c3 < 1);
            guard++;
        end
        clr_all();
        chk("lock_timeout", 64'(guard >= 100), 64'd0);
        chk("lock_trace_len", 64'(tr.size()), 64'd21);
        for (int k = 0; k < tr.size() && k < 21; k++) begin
            chk("lock_trace", 64'(tr[k]), (k == 16) ? 64'd3 : 64'd0);
        end
        repeat (RD_LAT + 3) next_cycle();

        // Back-to-back reads 2 then 0: response slots and busy window.
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h10, 64'd0, 8'd0);
        @(negedge clk);
        busy_tr[0] = busy; rsp_tr[0] = rsp_valid;
        next_cycle();
        clr_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 64'd0, 8'd0);
        @(negedge clk);
        busy_tr[1] = busy; rsp_tr[1] = rsp_valid;
        next_cycle();
        clr_all();
        for (int k = 2; k < 6; k++) begin
            @(negedge clk);
            busy_tr[k] = busy; rsp_tr[k] = rsp_valid;
            next_cycle();
        end
        for (int k = 0; k < 6; k++) begin
            chk("lat_busy", 64'(busy_tr[k]), (k >= 1 && k <= 4) ? 64'd1 : 64'd0);
            chk("lat_rsp_valid", 64'(rsp_tr[k]), (k == 3) ? 64'h4 : (k == 4) ? 64'h1 : 64'h0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_req(i,
                        (i == 0) ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) != 0),
                        32'($urandom_range(0, 15)) << 3,
                        {$urandom, $urandom},
                        8'($urandom));
            end
            next_cycle();
        end
        clr_all();
        repeat (RD_LAT + 3) next_cycle();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
